// File: rtl/seq_match_sched_if.sv
// Handshake and result bundle between symbol sources, the shared
// 1-2-3 sequence scheduler and downstream result logic.
interface seq_match_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] sym;
    logic [N_REQ-1:0]   sym_valid;
    logic [N_REQ-1:0]   sym_last;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               hit;
    logic               done;
    logic [ID_W-1:0]    done_id;
    logic [CNT_W-1:0]   match_cnt;
    logic               timeout;

    modport master (
        output req, sym, sym_valid, sym_last,
        input  gnt, busy, hit, done, done_id, match_cnt, timeout
    );

    modport slave (
        input  req, sym, sym_valid, sym_last,
        output gnt, busy, hit, done, done_id, match_cnt, timeout
    );
endinterface

// File: rtl/seq_match_sched.sv
// Round-robin scheduler sharing one 01,10+,11 sequence detector among
// N_REQ requesters; counts matches per session and reports on session end.
// Optional inactivity timeout: define SEQ_MATCH_TIMEOUT_EN.
module seq_match_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_match_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} fsm_t;
    typedef enum logic [1:0] {S0, S1, S2, S3}    eng_t;

    localparam logic [1:0]       SYM_A   = 2'b01;
    localparam logic [1:0]       SYM_B   = 2'b10;
    localparam logic [1:0]       SYM_C   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm_t             fsm_q,     fsm_d;
    eng_t             eng_q,     eng_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [ID_W-1:0]  owner_q,   owner_d;
    logic [ID_W-1:0]  last_q,    last_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             busy_q,    busy_d;
    logic             hit_q,     hit_d;
    logic             done_q,    done_d;
`ifdef SEQ_MATCH_TIMEOUT_EN
    logic [3:0]       idle_q,    idle_d;
    logic             tmo_q,     tmo_d;
    logic             tmo_hit;
`endif

    logic [1:0]       own_sym;
    logic             own_valid;
    logic             own_last;
    logic             own_req;
    logic             end_sess;
    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  idx;

    // One detector step on a valid symbol
    function automatic eng_t eng_step(eng_t e, logic [1:0] s);
        eng_t n;
        n = S0;
        if (s == SYM_A) begin
            n = S1;
        end else begin
            case (e)
                S1:      n = (s == SYM_B) ? S2 : S0;
                S2:      n = (s == SYM_B) ? S2 : ((s == SYM_C) ? S3 : S0);
                S3:      n = (s == SYM_C) ? S3 : S0;
                default: n = S0;
            endcase
        end
        return n;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            eng_q     <= S0;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= ID_W'(N_REQ - 1);
            done_id_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
            idle_q    <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            eng_q     <= eng_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            done_id_q <= done_id_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
`ifdef SEQ_MATCH_TIMEOUT_EN
            idle_q    <= idle_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Arbitration, session control and detector next-state
    always_comb begin
        fsm_d     = fsm_q;
        eng_d     = eng_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        done_id_d = done_id_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        done_d    = 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
        idle_d    = idle_q;
        tmo_d     = 1'b0;
        tmo_hit   = 1'b0;
`endif
        own_sym   = bus.sym[{owner_q, 1'b0} +: 2];
        own_valid = bus.sym_valid[owner_q];
        own_last  = bus.sym_last[owner_q];
        own_req   = bus.req[owner_q];
        end_sess  = 1'b0;

        // first requester above the previous owner, wrapping
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned d = 1; d <= N_REQ; d++) begin
            idx = ID_W'((32'(last_q) + d) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (fsm_q)
            IDLE: begin
                if (found) begin
                    fsm_d   = RUN;
                    gnt_d   = N_REQ'(1) << win;
                    owner_d = win;
                    eng_d   = S0;
                    hit_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SEQ_MATCH_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            RUN: begin
                if (own_valid) begin
                    eng_d = eng_step(eng_q, own_sym);
                    if (eng_q == S2 && own_sym == SYM_C && cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef SEQ_MATCH_TIMEOUT_EN
                    idle_d = '0;
                end else begin
                    idle_d  = idle_q + 4'd1;
                    tmo_hit = (idle_q == 4'd15);
`endif
                end
                hit_d    = (eng_d == S3);
                end_sess = own_valid && own_last;
`ifdef SEQ_MATCH_TIMEOUT_EN
                end_sess = end_sess || tmo_hit;
                tmo_d    = tmo_hit;
`endif
                if (end_sess) begin
                    fsm_d     = REPORT;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    last_d    = owner_q;
                end else if (!own_req) begin
                    fsm_d  = IDLE;
                    gnt_d  = '0;
                    last_d = owner_q;
`ifdef SEQ_MATCH_TIMEOUT_EN
                    tmo_d  = 1'b0;
`endif
                end
            end
            REPORT: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
        busy_d = (fsm_d == RUN);
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.hit       = hit_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = cnt_q;
`ifdef SEQ_MATCH_TIMEOUT_EN
    assign bus.timeout   = tmo_q;
`else
    assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_match_sched.sv
// Bench for seq_match_sched: directed and randomized sessions checked
// against a pattern-level model (suffix scan for 01,10+,11 matches).
module tb_seq_match_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_match_sched_if #(.N_REQ(N), .CNT_W(CW), .ID_W(IW)) bus ();
    seq_match_sched_if #(.N_REQ(N), .CNT_W(2),  .ID_W(IW)) bus2 ();

    assign bus2.req       = bus.req;
    assign bus2.sym       = bus.sym;
    assign bus2.sym_valid = bus.sym_valid;
    assign bus2.sym_last  = bus.sym_last;

    seq_match_sched #(.N_REQ(N), .CNT_W(CW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seq_match_sched #(.N_REQ(N), .CNT_W(2), .ID_W(IW)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_chk = 0;
    int n_pass = 0;
    int last_owner = N - 1;
    logic [1:0] hist[$];
    logic [1:0] stim[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int s);
        stim.push_back(2'(s));
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] r;
        r = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    // Requester with the smallest cyclic distance past the previous owner
    function automatic int model_pick(input logic [N-1:0] r);
        int best;
        int bestd;
        int d;
        best = -1;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - last_owner - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // Number of positions where the history ends with 01 10+ 11
    function automatic int model_cnt();
        int c;
        int j;
        c = 0;
        for (int k = 2; k < hist.size(); k++) begin
            if (hist[k] == 2'b11 && hist[k-1] == 2'b10) begin
                j = k - 1;
                while (j >= 0 && hist[j] == 2'b10) j--;
                if (j >= 0 && hist[j] == 2'b01) c++;
            end
        end
        return c;
    endfunction

    // History currently ends with 01 10+ 11+
    function automatic bit model_hit();
        int k;
        k = hist.size() - 1;
        if (k < 0 || hist[k] != 2'b11) return 1'b0;
        while (k >= 0 && hist[k] == 2'b11) k--;
        if (k < 0 || hist[k] != 2'b10) return 1'b0;
        while (k >= 0 && hist[k] == 2'b10) k--;
        return (k >= 0 && hist[k] == 2'b01);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive_lanes(input int w, input bit v, input logic [1:0] s, input bit l, input bit noise);
        for (int i = 0; i < N; i++) begin
            if (i == w) begin
                bus.sym_valid[i]   = v;
                bus.sym[2*i +: 2]  = s;
                bus.sym_last[i]    = l;
            end else if (noise) begin
                bus.sym_valid[i]   = 1'($urandom_range(0, 1));
                bus.sym[2*i +: 2]  = 2'($urandom_range(0, 3));
                bus.sym_last[i]    = 1'($urandom_range(0, 1));
            end else begin
                bus.sym_valid[i]   = 1'b0;
                bus.sym[2*i +: 2]  = 2'b00;
                bus.sym_last[i]    = 1'b0;
            end
        end
    endtask

    // Full session from IDLE: grant, stream stim (last on final), report
    task automatic run_session(input logic [N-1:0] reqv, input bit noise, input bit gaps);
        int w;
        int n;
        int c;
        w = model_pick(reqv);
        bus.req = reqv;
        drive_lanes(-1, 1'b0, 2'b00, 1'b0, noise);
        tick();
        check("grant", 32'(bus.gnt), 32'(onehot(w)));
        check("busy_run", 32'(bus.busy), 32'd1);
        check("cnt_clear", 32'(bus.match_cnt), 32'd0);
        check("hit_clear", 32'(bus.hit), 32'd0);
        hist.delete();
        n = stim.size();
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    drive_lanes(w, 1'b0, 2'b00, 1'b0, noise);
                    tick();
                    check("gap_busy", 32'(bus.busy), 32'd1);
                end
            end
            drive_lanes(w, 1'b1, stim[k], (k == n - 1), noise);
            tick();
            hist.push_back(stim[k]);
            c = model_cnt();
            check("hit", 32'(bus.hit), 32'(model_hit()));
            check("match_cnt", 32'(bus.match_cnt), 32'(sat(c, 255)));
            check("match_cnt_sat2", 32'(bus2.match_cnt), 32'(sat(c, 3)));
            if (k == n - 1) begin
                check("done", 32'(bus.done), 32'd1);
                check("done_id", 32'(bus.done_id), 32'(w));
                check("gnt_off", 32'(bus.gnt), 32'd0);
                check("busy_off", 32'(bus.busy), 32'd0);
                check("timeout_off", 32'(bus.timeout), 32'd0);
            end else begin
                check("no_done", 32'(bus.done), 32'd0);
                check("gnt_held", 32'(bus.gnt), 32'(onehot(w)));
            end
        end
        drive_lanes(w, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("done_pulse_end", 32'(bus.done), 32'd0);
        check("cnt_hold", 32'(bus.match_cnt), 32'(sat(model_cnt(), 255)));
        check("done_id_hold", 32'(bus.done_id), 32'(w));
        last_owner = w;
    endtask

    initial begin
        int w;
        int nch;
        bus.req = '0;
        bus.sym = '0;
        bus.sym_valid = '0;
        bus.sym_last = '0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cnt", 32'(bus.match_cnt), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // owner 0 stream with two matches
        stim.delete();
        add(1); add(2); add(3); add(3); add(0); add(1); add(2); add(3);
        run_session(4'b0001, 1'b0, 1'b0);

        // round robin between requesters 1 and 2 with req held
        for (int r = 0; r < 4; r++) begin
            stim.delete();
            add(0);
            run_session(4'b0110, 1'b0, 1'b0);
        end

        // owner 2 while others wiggle their lanes
        stim.delete();
        add(1); add(1); add(2); add(2); add(3);
        run_session(4'b0100, 1'b1, 1'b0);

        // five matches: narrow counter saturates
        stim.delete();
        for (int r = 0; r < 5; r++) begin
            add(1); add(2); add(3);
        end
        run_session(4'b1000, 1'b0, 1'b0);

        // abort by req drop, then next pending requester served
        w = model_pick(4'b1011);
        bus.req = 4'b1011;
        tick();
        check("abort_grant", 32'(bus.gnt), 32'(onehot(w)));
        hist.delete();
        stim.delete();
        add(1); add(2); add(3); add(1); add(2);
        for (int k = 0; k < 5; k++) begin
            drive_lanes(w, 1'b1, stim[k], 1'b0, 1'b0);
            tick();
            hist.push_back(stim[k]);
        end
        bus.req[w] = 1'b0;
        drive_lanes(w, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("abort_gnt", 32'(bus.gnt), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_no_done", 32'(bus.done), 32'd0);
        check("abort_cnt", 32'(bus.match_cnt), 32'(model_cnt()));
        last_owner = w;
        stim.delete();
        add(1); add(2); add(2); add(3);
        run_session(bus.req, 1'b0, 1'b0);

        // asynchronous reset in the middle of a session
        w = model_pick(4'b1111);
        bus.req = 4'b1111;
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive_lanes(w, 1'b1, 2'(k), 1'b0, 1'b0);
            tick();
        end
        check("pre_rst_hit", 32'(bus.hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(bus.gnt), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hit", 32'(bus.hit), 32'd0);
        check("arst_cnt", 32'(bus.match_cnt), 32'd0);
        check("arst_done_id", 32'(bus.done_id), 32'd0);
        #2 rst_n = 1'b1;
        bus.req = '0;
        drive_lanes(-1, 1'b0, 2'b00, 1'b0, 1'b0);
        last_owner = N - 1;
        tick();
        check("post_rst_idle", 32'(bus.gnt), 32'd0);

        // randomized sessions
        for (int r = 0; r < 16; r++) begin
            stim.delete();
            nch = $urandom_range(1, 4);
            for (int c = 0; c < nch; c++) begin
                case ($urandom_range(0, 3))
                    0: begin add(1); add(2); add(3); end
                    1: begin add(1); add(2); add(2); add(3); add(3); end
                    2: add(int'($urandom_range(0, 3)));
                    default: begin add(3); add(1); add(2); end
                endcase
            end
            run_session(4'($urandom_range(1, 15)), 1'b1, 1'b1);
        end

        // silent owner after one symbol
        bus.req = 4'b0001;
        w = model_pick(4'b0001);
        tick();
        drive_lanes(w, 1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        drive_lanes(w, 1'b0, 2'b00, 1'b0, 1'b0);
`ifdef SEQ_MATCH_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c < 16) begin
                check("tmo_wait_done", 32'(bus.done), 32'd0);
                check("tmo_wait_busy", 32'(bus.busy), 32'd1);
            end else begin
                check("tmo_done", 32'(bus.done), 32'd1);
                check("tmo_flag", 32'(bus.timeout), 32'd1);
                check("tmo_done_id", 32'(bus.done_id), 32'(w));
            end
        end
        tick();
        check("tmo_flag_end", 32'(bus.timeout), 32'd0);
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("silent_gnt", 32'(bus.gnt), 32'(onehot(w)));
            check("silent_timeout", 32'(bus.timeout), 32'd0);
        end
        drive_lanes(w, 1'b1, 2'b00, 1'b1, 1'b0);
        tick();
        check("silent_done", 32'(bus.done), 32'd1);
        drive_lanes(w, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
`endif
        bus.req = '0;
        last_owner = w;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_match_sched.md
Name: seq_match_sched

Overview:
- Round-robin scheduler that shares one 1-2-3 symbol-sequence detection engine among N_REQ requesters.
- Grants one requester at a time and resets the engine at session start.
- Feeds the owner's 2-bit symbol stream into the engine and counts completed matches.
- Reports the per-session count on the owner's last symbol. Sits between the symbol sources and downstream result logic.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 8, width of per-session match counter
ID_W, 2, width of requester index; must equal clog2(N_REQ)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-requester session request, level
sym  in  2*N_REQ  packed symbols; requester i at [2i+1:2i]
sym_valid  in  N_REQ  per-requester symbol valid
sym_last  in  N_REQ  per-requester last-symbol flag, qualified by sym_valid
gnt  out  N_REQ  one-hot grant, registered
busy  out  1  high while a session is in RUN
hit  out  1  engine currently in S3 (sequence held)
done  out  1  one-cycle pulse at session end
done_id  out  ID_W  index of requester whose session ended
match_cnt  out  CNT_W  matches in current/last session
timeout  out  1  session ended by inactivity (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, engine=S0, gnt=0, busy=0, hit=0, done=0, done_id=0, match_cnt=0, timeout=0. The rr pointer is set so requester 0 has first priority.
- FSM states: IDLE, RUN, REPORT.
- IDLE, no req: stay.
- IDLE, any req bit high:
  - Winner is the first set bit searching upward from (last_owner+1) mod N_REQ, wrapping.
  - Next edge: FSM=RUN, gnt=onehot(winner), busy=1, engine=S0, match_cnt=0.
  - Grant latency: 1 cycle after req is sampled.
- RUN, symbol rules:
  - Only sym/sym_valid/sym_last of the owner are used; all other requesters' inputs are ignored.
  - Each cycle with sym_valid[owner]=1, the engine steps on the owner's symbol s.
  - Any state, s=01 -> S1.
  - S1, s=10 -> S2.
  - S2, s=10 -> S2.
  - S2, s=11 -> S3.
  - S3, s=11 -> S3.
  - All other (state, s) combinations -> S0.
  - No valid: hold state.
- RUN, outputs:
  - hit = (engine==S3), registered state.
  - match_cnt += 1 on each S2->S3 transition; saturates at 2^CNT_W-1. Staying in S3 does not count again.
- RUN, session end and abort:
  - sym_valid[owner] & sym_last[owner]: that symbol is processed normally, including any count increment. Next edge: FSM=REPORT, gnt=0, busy=0, done=1, done_id=owner, last_owner=owner.
  - req[owner] drops while in RUN (no last): abort. Next edge: FSM=IDLE, gnt=0, busy=0, no done pulse, last_owner=owner. match_cnt keeps its partial value.
- REPORT: done=1 for exactly this cycle. Next edge: FSM=IDLE, done=0.
  - match_cnt and done_id hold until the next session's grant.
  - hit holds the final engine state until the next grant clears it.
- A re-request by the same owner is served again only after all other pending requesters (round-robin).
- Minimum gap between sessions: REPORT + IDLE = 2 cycles.
- Reset asserted mid-session: immediate return to reset values; no done.

Optional Feature:
- Macro: SEQ_MATCH_TIMEOUT_EN.
- Defined:
  - A 4-bit idle counter clears on entry to RUN and on every valid owner symbol, and increments on other RUN cycles.
  - When it reaches 15, the next edge ends the session as if last had been seen: REPORT, done=1, done_id=owner, plus timeout=1 for the same single cycle.
- Undefined: no counter; timeout tied 0; a session ends only by last or by req drop.

Test Plan:
- Reset then req=0001. Owner 0 streams 01,10,11,11,00,01,10,11(last) -> gnt=0001 one cycle after req. done pulse with done_id=0, match_cnt=2; hit high during the 11 symbols.
- req=0110 held from IDLE, last_owner=0, each session one symbol 00 with last -> grants in order 0010, 0100, 0010, 0100. done_id 1,2,1,2; match_cnt=0.
- Owner 2 streams 01,01,10,10,11 (last); requester 3 drives sym_valid with 01,10,11 during the session -> match_cnt=1; requester 3 input has no effect.
- CNT_W=2; 5 repetitions of 01,10,11 -> match_cnt saturates at 3.
- Owner drops req mid-stream after 01,10 -> gnt=0 next edge, no done, next pending requester granted. Separately, rst_n low mid-RUN -> all outputs 0 asynchronously.
- With SEQ_MATCH_TIMEOUT_EN: owner sends 01 then stays silent -> done=1 and timeout=1 on the same cycle, exactly 16 cycles after the last valid symbol (counter reaching 15 plus one edge to REPORT). Without the macro: gnt stays held, timeout=0.
